// File: rtl/frame_renderer.sv
`default_nettype none
// ============================================================================
// frame_renderer: rasterises a 128x96 RGB332 frame (background plus two
// sprites) into the ping-pong frame buffer, one pixel per clock.
// Revision: 1.0
// ============================================================================
module frame_renderer #(
  parameter logic [7:0] BG_COLOR    = 8'h00,
  parameter logic [7:0] TRANSPARENT = 8'hE3,
  parameter int         SPR_W       = 16,
  parameter int         SPR_H       = 32,
  parameter int         ROM_AW      = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [6:0]        p1_x,
  input  logic [6:0]        p1_y,
  input  logic [6:0]        p2_x,
  input  logic [6:0]        p2_y,
  output logic [ROM_AW-1:0] p1_rom_addr,
  input  logic [7:0]        p1_rom_data,
  output logic [ROM_AW-1:0] p2_rom_addr,
  input  logic [7:0]        p2_rom_data,
  output logic [13:0]       addr_write,
  output logic [7:0]        data_write,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam logic [6:0]  X_LAST    = 7'd127;
  localparam logic [6:0]  Y_LAST    = 7'd95;
  localparam logic [13:0] PIX_LAST  = 14'd12287;
  localparam logic [7:0]  SPR_W_LEN = 8'(SPR_W);
  localparam logic [7:0]  SPR_H_LEN = 8'(SPR_H);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  x_q, x_d, y_q, y_d;
  logic        flush_q, flush_d;
  logic [6:0]  p1x_q, p1x_d, p1y_q, p1y_d, p2x_q, p2x_d, p2y_q, p2y_d;
  logic        overrun_q, overrun_d;

  logic        s1_valid_q, s1_in1_q, s1_in2_q;
  logic [13:0] s1_addr_q;
  logic [13:0] addr_q;
  logic [7:0]  data_q;
  logic        done_q;

  logic        w_in1, w_in2;
  logic [7:0]  w_pix;

  // Compare in 8 bits so a sprite near the right/bottom edge clips, never wraps.
  function automatic logic span_hit(input logic [6:0] c, input logic [6:0] p,
                                    input logic [7:0] len);
    return ({1'b0, c} >= {1'b0, p}) && ({1'b0, c} < ({1'b0, p} + len));
  endfunction

  function automatic logic [ROM_AW-1:0] rom_off(input logic [6:0] x, input logic [6:0] y,
                                                input logic [6:0] px, input logic [6:0] py);
    logic [6:0]  dx;
    logic [6:0]  dy;
    logic [15:0] off;
    dx  = x - px;
    dy  = y - py;
    off = 16'(dy) * 16'(SPR_W) + 16'(dx);
    return off[ROM_AW-1:0];
  endfunction

  assign w_in1 = span_hit(x_q, p1x_q, SPR_W_LEN) && span_hit(y_q, p1y_q, SPR_H_LEN);
  assign w_in2 = span_hit(x_q, p2x_q, SPR_W_LEN) && span_hit(y_q, p2y_q, SPR_H_LEN);

  assign p1_rom_addr = w_in1 ? rom_off(x_q, y_q, p1x_q, p1y_q) : '0;
  assign p2_rom_addr = w_in2 ? rom_off(x_q, y_q, p2x_q, p2y_q) : '0;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    flush_d   = flush_q;
    p1x_d     = p1x_q;
    p1y_d     = p1y_q;
    p2x_d     = p2x_q;
    p2y_d     = p2y_q;
    overrun_d = overrun_q;
    if (frame_start && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_SCAN;
          x_d     = '0;
          y_d     = '0;
          p1x_d   = p1_x;
          p1y_d   = p1_y;
          p2x_d   = p2_x;
          p2y_d   = p2_y;
        end
      end
      S_SCAN: begin
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) begin
            y_d     = '0;
            flush_d = 1'b0;
            state_d = S_FLUSH;
          end else begin
            y_d = y_q + 7'd1;
          end
        end else begin
          x_d = x_q + 7'd1;
        end
      end
      S_FLUSH: begin
        flush_d = 1'b1;
        if (flush_q) begin
          flush_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      flush_q   <= 1'b0;
      p1x_q     <= '0;
      p1y_q     <= '0;
      p2x_q     <= '0;
      p2y_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      flush_q   <= flush_d;
      p1x_q     <= p1x_d;
      p1y_q     <= p1y_d;
      p2x_q     <= p2x_d;
      p2y_q     <= p2y_d;
      overrun_q <= overrun_d;
    end
  end

  // Player 1 wins wherever both sprites are opaque.
  always_comb begin
    w_pix = BG_COLOR;
    if (s1_in1_q && (p1_rom_data != TRANSPARENT)) begin
      w_pix = p1_rom_data;
    end else if (s1_in2_q && (p2_rom_data != TRANSPARENT)) begin
      w_pix = p2_rom_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_in1_q   <= 1'b0;
      s1_in2_q   <= 1'b0;
      addr_q     <= '0;
      data_q     <= BG_COLOR;
      done_q     <= 1'b0;
    end else begin
      s1_valid_q <= (state_q == S_SCAN);
      s1_addr_q  <= {y_q, x_q};
      s1_in1_q   <= w_in1;
      s1_in2_q   <= w_in2;
      if (s1_valid_q) begin
        addr_q <= s1_addr_q;
        data_q <= w_pix;
      end
      done_q <= s1_valid_q && (s1_addr_q == PIX_LAST);
    end
  end

  assign addr_write = addr_q;
  assign data_write = data_q;
  assign done       = done_q;
  assign busy       = (state_q != S_IDLE);
  assign overrun    = overrun_q;

endmodule
`default_nettype wire
